// File: rtl/cube_state_deserializer.sv
// Assembles 15 host-link bytes into a 120-bit packed cube-state word, range-checks
// the orientation/position fields and releases the word to the buffer stage as d/load.
module cube_state_deserializer #(
  parameter int unsigned NUM_BYTES      = 15,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          CHECK_EN       = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   hold,
  output logic                   load,
  output logic [NUM_BYTES*8-1:0] d,
  output logic                   err_range,
  output logic                   err_timeout,
  output logic [15:0]            frame_cnt
);

  localparam int unsigned WORD_W     = NUM_BYTES * 8;
  localparam int unsigned CNT_W      = $clog2(NUM_BYTES);
  localparam int unsigned IDX_W      = $clog2(WORD_W);
  localparam int unsigned TMR_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NUM_PIECES = 12;
  localparam int unsigned CDIR_LSB   = 36;
  localparam int unsigned EPOS_LSB   = 60;

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);

  // LOAD waits out hold; DRAIN is the cycle in which the registered load pulse is high.
  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    LOAD    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  timer;
  logic [WORD_W-1:0] asm_q;
  logic [IDX_W-1:0]  byte_lsb_c;
  logic              range_bad_c;
  logic              xfer_c;

  assign xfer_c     = in_valid && in_ready;
  assign byte_lsb_c = IDX_W'({count, 3'b000});

  // Any edge position >= 12 or corner orientation == 3 marks an impossible cube state.
  always_comb begin
    range_bad_c = 1'b0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      if (asm_q[EPOS_LSB + 4*i +: 4] >= 4'd12) range_bad_c = 1'b1;
      if (asm_q[CDIR_LSB + 2*i +: 2] == 2'd3)  range_bad_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      count       <= '0;
      timer       <= '0;
      asm_q       <= '0;
      in_ready    <= 1'b1;
      load        <= 1'b0;
      d           <= '0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      load        <= 1'b0;
      err_range   <= 1'b0;
      err_timeout <= 1'b0;

      case (state)
        COLLECT: begin
          if (xfer_c) begin
            asm_q[byte_lsb_c +: 8] <= in_data;
            timer                  <= '0;
            if (count == LAST_BYTE) begin
              count    <= '0;
              in_ready <= 1'b0;
              state    <= CHECK;
            end else begin
              count <= count + 1'b1;
            end
          end else if (count != '0) begin
            if (timer == TMR_LAST) begin
              err_timeout <= 1'b1;
              count       <= '0;
              timer       <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        CHECK: begin
          if (CHECK_EN && range_bad_c) begin
            err_range <= 1'b1;
            in_ready  <= 1'b1;
            state     <= COLLECT;
          end else if (!hold) begin
            d         <= asm_q;
            load      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= DRAIN;
          end else begin
            state <= LOAD;
          end
        end

        LOAD: begin
          if (!hold) begin
            d         <= asm_q;
            load      <= 1'b1;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= DRAIN;
          end
        end

        DRAIN: begin
          in_ready <= 1'b1;
          state    <= COLLECT;
        end

        default: begin
          in_ready <= 1'b1;
          count    <= '0;
          timer    <= '0;
          state    <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cube_state_deserializer.sv
// Directed bench for cube_state_deserializer: one checked instance per CHECK_EN setting.
module tb_cube_state_deserializer;

  logic         clk;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         hold;

  logic         in_ready,  load,  err_range,  err_timeout;
  logic [119:0] d;
  logic [15:0]  frame_cnt;
  logic         in_ready0, load0, err_range0, err_timeout0;
  logic [119:0] d0;
  logic [15:0]  frame_cnt0;

  int vectors     = 0;
  int miscompares = 0;
  int exp_cnt     = 0;
  int exp_cnt0    = 0;
  int waited;

  logic [119:0] frame_a, frame_b, ramp, bad_epos, bad_cdir;

  cube_state_deserializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .load(load), .d(d), .err_range(err_range), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  cube_state_deserializer #(.CHECK_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .hold(hold), .load(load0), .d(d0), .err_range(err_range0), .err_timeout(err_timeout0),
    .frame_cnt(frame_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [119:0] obs, input logic [119:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives bytes 0..n-1 of w, one per cycle, LSB byte first.
  task automatic send(input logic [119:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      chk("in_ready_byte", 120'(in_ready), 120'd1);
      in_valid = 1'b1;
      in_data  = w[8*k +: 8];
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  // Called at the negedge of cycle N+1 after the last byte (hold low).
  task automatic expect_load(input string tag, input logic [119:0] w);
    chk({tag, "_check_ready"}, 120'(in_ready), 120'd0);
    chk({tag, "_check_load"},  120'(load),     120'd0);
    @(negedge clk);
    exp_cnt++;
    chk({tag, "_load"},      120'(load),      120'd1);
    chk({tag, "_d"},         d,               w);
    chk({tag, "_frame_cnt"}, 120'(frame_cnt), 120'(16'(exp_cnt)));
    chk({tag, "_err_range"}, 120'(err_range), 120'd0);
    chk({tag, "_ready_n2"},  120'(in_ready),  120'd0);
    @(negedge clk);
    chk({tag, "_load_off"},  120'(load),      120'd0);
    chk({tag, "_ready_n3"},  120'(in_ready),  120'd1);
  endtask

  // Called at cycle N+1 for a frame that must be range-rejected by dut and loaded by dut0.
  task automatic expect_reject(input string tag, input logic [119:0] w, input logic [119:0] d_prev);
    chk({tag, "_check_ready"}, 120'(in_ready), 120'd0);
    @(negedge clk);
    exp_cnt0++;
    chk({tag, "_err_range"}, 120'(err_range),  120'd1);
    chk({tag, "_no_load"},   120'(load),       120'd0);
    chk({tag, "_d_kept"},    d,                d_prev);
    chk({tag, "_ready"},     120'(in_ready),   120'd1);
    chk({tag, "_cnt_kept"},  120'(frame_cnt),  120'(16'(exp_cnt)));
    chk({tag, "_nochk_load"}, 120'(load0),     120'd1);
    chk({tag, "_nochk_d"},   d0,               w);
    chk({tag, "_nochk_err"}, 120'(err_range0), 120'd0);
    chk({tag, "_nochk_cnt"}, 120'(frame_cnt0), 120'(16'(exp_cnt0)));
    @(negedge clk);
    chk({tag, "_err_off"},   120'(err_range),  120'd0);
    @(negedge clk);
  endtask

  initial begin
    frame_a  = {8'hFF, 8'hFB, 8'hA9, 8'h87, 8'h65, 8'h43, 8'h21, 8'hB6,
                8'h24, 8'h12, 8'h25, 8'h0F, 8'h96, 8'h3C, 8'hA5};
    frame_b  = {8'h5A, 8'hBA, 8'h98, 8'h76, 8'h54, 8'h32, 8'h10, 8'h00,
                8'h00, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    ramp     = 120'h0E0D0C0B0A09080706050403020100;
    bad_epos = frame_a;
    bad_epos[63:56] = 8'hC6;
    bad_cdir = frame_a;
    bad_cdir[47:40] = 8'h03;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  120'(in_ready),    120'd1);
    chk("rst_load",      120'(load),        120'd0);
    chk("rst_d",         d,                 120'd0);
    chk("rst_err_range", 120'(err_range),   120'd0);
    chk("rst_err_tmo",   120'(err_timeout), 120'd0);
    chk("rst_frame_cnt", 120'(frame_cnt),   120'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean frame, back-to-back bytes, load two cycles after the last byte.
    send(frame_a, 15);
    exp_cnt0++;
    expect_load("frame_a", frame_a);
    chk("nochk_frame_a_d", d0, frame_a);

    // Ramp frame breaks both corner-orientation and edge-position rules.
    send(ramp, 15);
    expect_reject("ramp", ramp, frame_a);

    // Edge position field 0 = 0xC.
    send(bad_epos, 15);
    expect_reject("bad_epos", bad_epos, frame_a);
    chk("nochk_epos_nibble", 120'(d0[63:60]), 120'h0C);

    // Corner orientation field 2 = 3.
    send(bad_cdir, 15);
    expect_reject("bad_cdir", bad_cdir, frame_a);

    // Partial frame then idle until the timeout fires exactly once.
    send(frame_b, 5);
    waited = 0;
    while (!err_timeout && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("timeout_latency", 120'(waited), 120'd1024);
    chk("timeout_nochk",   120'(err_timeout0), 120'd1);
    chk("timeout_ready",   120'(in_ready), 120'd1);
    @(negedge clk);
    chk("timeout_single",  120'(err_timeout), 120'd0);
    send(frame_b, 15);
    exp_cnt0++;
    expect_load("after_timeout", frame_b);

    // hold at LOAD; upstream keeps a junk byte valid that must not be consumed.
    hold = 1'b1;
    send(frame_a, 15);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    for (int c = 0; c < 10; c++) begin
      chk("hold_no_load",  120'(load),     120'd0);
      chk("hold_no_ready", 120'(in_ready), 120'd0);
      @(negedge clk);
    end
    hold = 1'b0;
    @(negedge clk);
    exp_cnt++;
    exp_cnt0++;
    chk("hold_release_load", 120'(load),      120'd1);
    chk("hold_release_d",    d,               frame_a);
    chk("hold_release_cnt",  120'(frame_cnt), 120'(16'(exp_cnt)));
    chk("hold_release_rdy",  120'(in_ready),  120'd0);
    @(negedge clk);
    chk("post_load_ready",   120'(in_ready),  120'd1);
    send(frame_b, 15);
    exp_cnt0++;
    expect_load("after_hold", frame_b);

    // Reset after byte 7 discards the partial frame.
    send(frame_a, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    exp_cnt0 = 0;
    chk("midrst_ready", 120'(in_ready),  120'd1);
    chk("midrst_d",     d,               120'd0);
    chk("midrst_cnt",   120'(frame_cnt), 120'd0);
    send(frame_b, 15);
    expect_load("after_midrst", frame_b);

    // Reset while a held frame waits in LOAD: it must never be released.
    hold = 1'b1;
    send(frame_a, 15);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    exp_cnt = 0;
    chk("loadrst_ready", 120'(in_ready),  120'd1);
    chk("loadrst_d",     d,               120'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("loadrst_no_load", 120'(load), 120'd0);
    end

    // frame_cnt wrap from 0xFFFF.
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("wrap_preload", 120'(frame_cnt), 120'hFFFF);
    send(frame_a, 15);
    exp_cnt = 16'hFFFF;
    expect_load("wrap", frame_a);
    chk("wrap_zero", 120'(frame_cnt), 120'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
